// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared types and constants for the free-list manager
package free_list_pkg;

    localparam int ENTRIES = 40;
    localparam int IDX_W   = 6;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        INIT,
        READY
    } fl_state_e;

    // Last index of the pool, which is also the tail once the list is built
    localparam idx_t LAST_IDX   = idx_t'(ENTRIES - 1);
    // Final link written by the init sequencer: next[ENTRIES-2] = ENTRIES-1
    localparam idx_t INIT_LAST  = idx_t'(ENTRIES - 2);
    // Count value of a completely free pool
    localparam idx_t FULL_COUNT = idx_t'(ENTRIES);

endpackage

// File: rtl/free_list_ctrl.sv
// rtl/free_list_ctrl.sv - linked-list free-index manager driving an external next-pointer memory
module free_list_ctrl
    import free_list_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    output logic             alloc_valid,
    input  logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             free_valid,
    input  logic [IDX_W-1:0] free_idx,
    output logic [IDX_W-1:0] count,
    output logic             init_done,
    output logic             err,
    output logic [IDX_W-1:0] mem_raddr,
    output logic             mem_ren,
    input  logic [IDX_W-1:0] mem_rdata,
    output logic [IDX_W-1:0] mem_waddr,
    output logic             mem_wen,
    output logic [IDX_W-1:0] mem_wdata
);

    fl_state_e state_q, state_d;
    idx_t      init_ptr_q, init_ptr_d;
    idx_t      head_q, head_d;
    idx_t      tail_q, tail_d;
    idx_t      count_q, count_d;
    logic      err_q, err_d;

    logic      alloc_fire;
    logic      free_accept;
    logic      wen_raw;

    // The read port always follows the head so the successor of the head is
    // available combinationally on mem_rdata whenever an alloc fires.
    assign mem_ren   = 1'b1;
    assign mem_raddr = head_q;

    assign alloc_idx = head_q;
    assign count     = count_q;
    assign init_done = (state_q == READY);
    assign err       = err_q;

    // Writes are suppressed while reset is held so nothing lands in the memory
    // from the pre-reset state.
    assign mem_wen   = wen_raw & ~reset;

    // Next-state and memory-port decode for init sequencing and alloc/free handling
    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        err_d       = err_q;
        wen_raw     = 1'b0;
        mem_waddr   = tail_q;
        mem_wdata   = free_idx;
        alloc_valid = 1'b0;
        alloc_fire  = 1'b0;
        free_accept = 1'b0;

        case (state_q)
            INIT: begin
                // Chain every entry to its successor: next[i] = i + 1.
                wen_raw    = 1'b1;
                mem_waddr  = init_ptr_q;
                mem_wdata  = init_ptr_q + 1'b1;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == INIT_LAST) begin
                    state_d = READY;
                    count_d = FULL_COUNT;
                    head_d  = '0;
                    tail_d  = LAST_IDX;
                end
                // Returns are meaningless before the list exists.
                if (free_valid) begin
                    err_d = 1'b1;
                end
            end

            READY: begin
                alloc_valid = (count_q != '0) & ~reset;
                alloc_fire  = alloc_valid & alloc_ready;
                // A full pool can only take a return if an entry leaves in the same cycle.
                free_accept = free_valid & (alloc_fire | (count_q != FULL_COUNT));

                if (free_valid && !free_accept) begin
                    err_d = 1'b1;
                end

                case ({alloc_fire, free_accept})
                    2'b10: begin
                        // With one entry left the head stays put; it is stale
                        // until the next return overwrites it.
                        if (count_q != idx_t'(1)) begin
                            head_d = mem_rdata;
                        end
                        count_d = count_q - 1'b1;
                    end
                    2'b01: begin
                        if (count_q == '0) begin
                            head_d = free_idx;
                            tail_d = free_idx;
                        end else begin
                            wen_raw = 1'b1;
                            tail_d  = free_idx;
                        end
                        count_d = count_q + 1'b1;
                    end
                    2'b11: begin
                        if (count_q == idx_t'(1)) begin
                            // The only entry leaves and the returned one replaces it.
                            head_d = free_idx;
                            tail_d = free_idx;
                        end else begin
                            head_d  = mem_rdata;
                            wen_raw = 1'b1;
                            tail_d  = free_idx;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State, list pointers, count and sticky error register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            head_q     <= '0;
            tail_q     <= LAST_IDX;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/free_list_ctrl.md
Name: free_list_ctrl

Overview:
Free-list manager for a 40-entry pool of 6-bit indices, built as a linked list.
- Owns head/tail/count state and an init sequencer.
- Drives the external 40x6 next-pointer memory (1 async-read port, 1 sync-write port) that sits directly downstream of it.
- Hands out free indices to an allocating consumer and accepts returned indices from a deallocating producer.

Parameters:
ENTRIES, 40, number of pool entries / memory depth
IDX_W, 6, index width = ceil(log2(ENTRIES))

Ports:
clock  in  1  sole clock; also drives the memory R0_clk and W0_clk
reset  in  1  synchronous, active-high
alloc_valid  out  1  a free index is available on alloc_idx
alloc_ready  in  1  consumer takes alloc_idx this cycle
alloc_idx  out  IDX_W  index at the head of the list
free_valid  in  1  return free_idx to the pool this cycle
free_idx  in  IDX_W  index being returned
count  out  IDX_W  number of free entries (0..ENTRIES)
init_done  out  1  init sequence complete
err  out  1  sticky protocol-error flag
mem_raddr  out  IDX_W  to memory R0_addr
mem_ren  out  1  to memory R0_en
mem_rdata  in  IDX_W  from memory R0_data (combinational read)
mem_waddr  out  IDX_W  to memory W0_addr
mem_wen  out  1  to memory W0_en
mem_wdata  out  IDX_W  to memory W0_data

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=INIT, init_ptr=0, head=0, tail=ENTRIES-1, count=0, alloc_valid=0, init_done=0, err=0, mem_wen=0.
- State machine: INIT -> READY. Reset asserted in any state, mid-operation included, returns to INIT and rebuilds the whole list. Outstanding allocations are forgotten.
- INIT:
  - Each cycle: mem_wen=1, mem_waddr=init_ptr, mem_wdata=init_ptr+1, then init_ptr++.
  - After the write at init_ptr=ENTRIES-2, go to READY with count=ENTRIES, head=0, tail=ENTRIES-1.
  - That is 39 write cycles; init_done=1 on the 40th cycle after reset deasserts.
  - Any free_valid during INIT is dropped and sets err.
- READY:
  - mem_ren=1 and mem_raddr=head at all times, so the memory never returns X on the path used.
  - alloc_valid = (count!=0); alloc_idx = head.
  - Alloc fire = alloc_valid & alloc_ready.
- Alloc only: head <= mem_rdata; count-1. If count was 1, head is left unchanged (now stale). No write.
- Free only:
  - count==0: head <= free_idx, tail <= free_idx, no memory write.
  - count>0: write next[tail] <= free_idx (mem_wen=1, mem_waddr=tail, mem_wdata=free_idx), then tail <= free_idx.
  - count+1.
- Alloc and free in the same cycle:
  - count==1: head <= free_idx, tail <= free_idx, count stays 1, no write.
  - count>1: head <= mem_rdata, write next[tail] <= free_idx, tail <= free_idx, count unchanged.
- Free with count==ENTRIES and no alloc fire: dropped, err <= 1.
- Duplicate-index frees are not detected; callers guarantee uniqueness.
- Latency:
  - An alloc fire in cycle N presents the next head in cycle N+1.
  - A free in cycle N is allocatable from N+1 when it is the only entry, otherwise once it reaches the head.
- Width rule: count is IDX_W bits; ENTRIES=40 fits in 6 bits.

Decomposition:
- Package free_list_pkg holds:
  - ENTRIES and IDX_W localparams;
  - typedef idx_t = logic [IDX_W-1:0];
  - enum fl_state_e {INIT, READY}.
- The memory is instantiated by the parent and is not inside this block.
- No sub-module; head, tail, count and the FSM sit in one always_ff block.

Test Plan:
- Reset released -> mem_wen high for exactly 39 cycles writing (0,1)..(38,39); init_done=1 at cycle 40; count=40; alloc_idx=0.
- 40 back-to-back allocs with alloc_ready=1 -> alloc_idx sequence 0..39; count=0; alloc_valid=0; a further alloc_ready has no effect.
- Empty pool, free idx 7 -> next cycle alloc_valid=1, alloc_idx=7, count=1, no memory write.
- count=1 (head=7), simultaneous alloc and free of idx 12 -> 7 is consumed, next alloc_idx=12, count=1, no write.
- count=40, free idx 5 -> dropped, err=1 sticky, count stays 40; free during INIT also sets err.
- Reset asserted for 1 cycle after 10 allocs -> INIT re-entered, 39 writes repeated, count=40, alloc_idx=0, err=0.
